// File: rtl/color_issue_arbiter_pkg.sv
// Shared definitions for the color issue arbiter: FSM state encoding and the
// constant log2 helper used to size tag fields.
package color_issue_arbiter_pkg;

    typedef enum logic {
        ARB_SCAN  = 1'b0,
        ARB_PROBE = 1'b1
    } arb_state_t;

    // Ceiling log2 for elaboration-time sizing; only ever called with constants.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/color_issue_arbiter_round_robin_picker.sv
// Combinational round-robin picker: rotate the request vector so rr_ptr sits at
// bit 0, priority-encode the lowest set bit, then rotate the index back.
module color_issue_arbiter_round_robin_picker #(
    parameter int COLORS      = 4,
    parameter int LOG2_COLORS = 2
) (
    input  logic [COLORS-1:0]      i_req,
    input  logic [LOG2_COLORS-1:0] i_rr_ptr,
    output logic                   o_found,
    output logic [LOG2_COLORS-1:0] o_index
);

    logic [COLORS-1:0]      w_rot;
    logic [LOG2_COLORS-1:0] w_offset;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < COLORS; i++) begin
            // Index arithmetic is LOG2_COLORS wide, so the rotation wraps for free.
            w_rot[i] = i_req[LOG2_COLORS'(i) + i_rr_ptr];
        end
    end

    always_comb begin
        w_offset = '0;
        for (int i = COLORS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_offset = LOG2_COLORS'(i);
            end
        end
    end

    assign o_found = |w_rot;
    assign o_index = i_rr_ptr + w_offset;

endmodule

// File: rtl/color_issue_arbiter.sv
// Round-robin issue arbiter feeding an in-flight tracker: probes one color at a
// time and issues it into a single registered output slot when the tracker has room.
module color_issue_arbiter
    import color_issue_arbiter_pkg::*;
#(
    parameter  int COLORS      = 4,
    parameter  int DATA_WIDTH  = 64,
    localparam int LOG2_COLORS = log2(COLORS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [COLORS-1:0]            req_valid,
    input  logic [COLORS*DATA_WIDTH-1:0] req_data,
    output logic [COLORS-1:0]            req_ready,
    output logic                         push,
    output logic [LOG2_COLORS-1:0]       push_tag,
    input  logic                         tracker_ready,
    output logic                         out_valid,
    output logic [LOG2_COLORS-1:0]       out_tag,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_ready
);

    arb_state_t             r_state;
    logic [LOG2_COLORS-1:0] r_rr_ptr;

    logic                   w_found;
    logic [LOG2_COLORS-1:0] w_pick;
    logic                   w_sel_valid;
    logic                   w_slot_free;
    logic                   w_issue;
    logic [DATA_WIDTH-1:0]  w_payload [COLORS];

    color_issue_arbiter_round_robin_picker #(
        .COLORS      (COLORS),
        .LOG2_COLORS (LOG2_COLORS)
    ) u_picker (
        .i_req    (req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_found  (w_found),
        .o_index  (w_pick)
    );

    always_comb begin
        for (int c = 0; c < COLORS; c++) begin
            w_payload[c] = req_data[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // push_tag is a flop, so tracker_ready depends on registers only and the
    // grant below cannot form a combinational loop through the tracker.
    assign w_sel_valid = req_valid[push_tag];
    assign w_slot_free = !out_valid || out_ready;
    assign w_issue     = (r_state == ARB_PROBE) && w_sel_valid && tracker_ready && w_slot_free;
    assign push        = w_issue;

    always_comb begin
        req_ready = '0;
        if (w_issue) begin
            req_ready[push_tag] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ARB_SCAN;
            r_rr_ptr <= '0;
            push_tag <= '0;
        end else begin
            case (r_state)
                ARB_SCAN: begin
                    if (w_found) begin
                        push_tag <= w_pick;
                        r_state  <= ARB_PROBE;
                    end
                end
                ARB_PROBE: begin
                    if (!w_sel_valid) begin
                        r_state <= ARB_SCAN;
                    end else if (!tracker_ready) begin
                        // Blocked color is skipped so it cannot hold up the others.
                        r_rr_ptr <= push_tag + 1'b1;
                        r_state  <= ARB_SCAN;
                    end else if (w_slot_free) begin
                        r_rr_ptr <= push_tag + 1'b1;
                        r_state  <= ARB_SCAN;
                    end
                end
                default: r_state <= ARB_SCAN;
            endcase
        end
    end

    // NOTE: the payload register is reset too, so out_data reads zero after
    // reset rather than whatever was left from before.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_data  <= '0;
        end else if (w_issue) begin
            out_valid <= 1'b1;
            out_tag   <= push_tag;
            out_data  <= w_payload[push_tag];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_color_issue_arbiter.sv
// Directed bench for color_issue_arbiter with a per-tag occupancy model of the
// in-flight tracker (416 entries per tag, optional per-tag block mask).
module tb_color_issue_arbiter;

    localparam int COLORS     = 4;
    localparam int DW         = 64;
    localparam int TRACK_MAX  = 416;

    logic                 clk;
    logic                 rst_n;
    logic [COLORS-1:0]    req_valid;
    logic [COLORS*DW-1:0] req_data;
    logic [COLORS-1:0]    req_ready;
    logic                 push;
    logic [1:0]           push_tag;
    logic                 tracker_ready;
    logic                 out_valid;
    logic [1:0]           out_tag;
    logic [DW-1:0]        out_data;
    logic                 out_ready;

    logic [COLORS-1:0]    block_mask;
    int unsigned          occ [COLORS];
    int                   errors;
    int                   checks;
    longint unsigned      next_payload;

    color_issue_arbiter #(
        .COLORS     (COLORS),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .push          (push),
        .push_tag      (push_tag),
        .tracker_ready (tracker_ready),
        .out_valid     (out_valid),
        .out_tag       (out_tag),
        .out_data      (out_data),
        .out_ready     (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tracker model: never pops, so each tag fills up to TRACK_MAX entries.
    assign tracker_ready = !block_mask[push_tag] && (occ[push_tag] < TRACK_MAX);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < COLORS; i++) occ[i] <= 0;
        end else if (push) begin
            occ[push_tag] <= occ[push_tag] + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for a push, check it targets `tag`, then check the slot
    // captured the payload and give that color a fresh payload.
    task automatic expect_issue(input string name, input logic [1:0] tag, input int budget);
        bit              seen;
        logic [DW-1:0]   exp_data;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (push) seen = 1'b1;
        end
        check({name, " push seen"}, 64'(seen), 64'd1);
        check({name, " push_tag"}, 64'(push_tag), 64'(tag));
        check({name, " req_ready"}, 64'(req_ready), 64'(4'b0001 << tag));
        exp_data = req_data[int'(tag)*DW +: DW];
        @(posedge clk);
        #1;
        check({name, " out_valid"}, 64'(out_valid), 64'd1);
        check({name, " out_tag"}, 64'(out_tag), 64'(tag));
        check({name, " out_data"}, out_data, exp_data);
        req_data[int'(tag)*DW +: DW] = next_payload;
        next_payload = next_payload + 64'h1111;
    endtask

    initial begin
        int            stray;
        logic [DW-1:0] held_data;
        logic [DW-1:0] tag3_data;

        errors       = 0;
        checks       = 0;
        next_payload = 64'hA000_0000_0000_0100;
        rst_n        = 1'b1;
        req_valid    = 4'hF;
        out_ready    = 1'b1;
        block_mask   = 4'h0;
        for (int c = 0; c < COLORS; c++) req_data[c*DW +: DW] = 64'hC0DE_0000_0000_0000 + 64'(c);

        // 1: reset asserted between edges with all colors requesting
        #2 rst_n = 1'b0;
        #1;
        check("rst push", 64'(push), 64'd0);
        check("rst req_ready", 64'(req_ready), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_tag", 64'(out_tag), 64'd0);
        check("rst out_data", out_data, 64'd0);
        check("rst push_tag", 64'(push_tag), 64'd0);
        repeat (2) @(negedge clk);
        check("rst held push", 64'(push), 64'd0);

        // 2: single color stream, one issue every second cycle, payloads in order
        req_valid = 4'b0100;
        @(negedge clk);
        rst_n = 1'b1;
        expect_issue("solo2 a", 2'd2, 2);
        expect_issue("solo2 b", 2'd2, 2);
        expect_issue("solo2 c", 2'd2, 2);

        // 3: all colors, fair rotation starting at color 0
        req_valid = 4'h0;
        do_reset();
        req_valid = 4'hF;
        expect_issue("rr g0", 2'd0, 2);
        expect_issue("rr g1", 2'd1, 2);
        expect_issue("rr g2", 2'd2, 2);
        expect_issue("rr g3", 2'd3, 2);
        expect_issue("rr g4", 2'd0, 2);
        expect_issue("rr g5", 2'd1, 2);

        // 4: fill tag 0 in the tracker, then color 1 still gets through
        req_valid = 4'h0;
        do_reset();
        req_valid = 4'b0001;
        repeat (900) @(negedge clk);
        check("fill occ0", 64'(occ[0]), 64'(TRACK_MAX));
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (push) stray++;
        end
        check("fill no push", 64'(stray), 64'd0);
        req_valid = 4'b0011;
        expect_issue("fill tag1", 2'd1, 6);

        // 5: tag 1 blocked by the tracker is skipped, then served on release
        req_valid = 4'h0;
        do_reset();
        block_mask = 4'b0010;
        req_valid  = 4'hF;
        expect_issue("blk g0", 2'd0, 2);
        expect_issue("blk g2", 2'd2, 4);
        expect_issue("blk g3", 2'd3, 2);
        expect_issue("blk g0b", 2'd0, 2);
        block_mask = 4'h0;
        expect_issue("blk rel1", 2'd1, 8);

        // 6: output back-pressure holds the FSM in PROBE on tag 3
        req_valid = 4'h0;
        do_reset();
        out_ready = 1'b0;
        req_valid = 4'b1001;
        tag3_data = req_data[3*DW +: DW];
        expect_issue("bp g0", 2'd0, 2);
        held_data = out_data;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (push) stray++;
        end
        check("bp no push", 64'(stray), 64'd0);
        check("bp push_tag", 64'(push_tag), 64'd3);
        check("bp out_valid", 64'(out_valid), 64'd1);
        check("bp out_data", out_data, held_data);
        out_ready = 1'b1;
        #1;
        check("bp release push", 64'(push), 64'd1);
        check("bp release ready", 64'(req_ready), 64'(4'b1000));
        @(posedge clk);
        #1;
        check("bp tag3 out_tag", 64'(out_tag), 64'd3);
        check("bp tag3 out_data", out_data, tag3_data);

        // 7: async reset while PROBE is stalled with the slot full
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("r7 pre push_tag", 64'(push_tag), 64'd0);
        check("r7 pre out_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("r7 out_valid", 64'(out_valid), 64'd0);
        check("r7 push", 64'(push), 64'd0);
        check("r7 out_data", out_data, 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'hF;
        expect_issue("r7 restart", 2'd0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
